// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the data SRAM responder: lane geometry, byte-enable
// encodings, legal read-latency range and the access-kind decode.
package data_sram_responder_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  localparam logic [WORD_BYTES-1:0] WEN_READ = 4'b0000;
  localparam logic [WORD_BYTES-1:0] WEN_WORD = 4'b1111;
  localparam logic [WORD_BYTES-1:0] WEN_B0   = 4'b0001;
  localparam logic [WORD_BYTES-1:0] WEN_B1   = 4'b0010;
  localparam logic [WORD_BYTES-1:0] WEN_B2   = 4'b0100;
  localparam logic [WORD_BYTES-1:0] WEN_B3   = 4'b1000;
  localparam logic [WORD_BYTES-1:0] WEN_H0   = 4'b0011;
  localparam logic [WORD_BYTES-1:0] WEN_H1   = 4'b1100;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_WRITE
  } acc_kind_e;

endpackage

// File: rtl/data_sram_responder_sram_rd_pipe.sv
// Read-response delay line: DEPTH stages of {valid, data}. Each stage only
// loads data behind a valid beat, so the last stage holds its word between pulses.
module data_sram_responder_sram_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/data_sram_responder.sv
// Memory end of the EX-stage data SRAM port: byte-enabled word store, pipelined
// fixed-latency reads, sticky range-error capture and saturating access counters.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        range_err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("data_sram_responder: READ_LATENCY must be within 1..4");
  end

  logic [WORD_W-1:0] mem [DEPTH];
  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  acc_kind_e         kind;
  logic [WORD_W-1:0] rd_word;
  logic              range_err_q;
  logic [31:0]       err_addr_q;
  logic [31:0]       rd_count_q;
  logic [31:0]       wr_count_q;

  // Word index is taken from the offset, so the low two address bits never select.
  assign offset   = data_sram_addr - BASE_ADDR;
  assign in_range = (data_sram_addr >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH));
  assign idx      = offset[ADDR_W+1:2];

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    kind = ACC_IDLE;
    if (data_sram_en) begin
      kind = (data_sram_wen == WEN_READ) ? ACC_READ : ACC_WRITE;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; clearing it would
  // stop it mapping onto SRAM macros, and its power-up contents are undefined anyway.
  always_ff @(posedge clk) begin
    if (kind == ACC_WRITE && in_range) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (data_sram_wen[k]) begin
          mem[idx][k*BYTE_W +: BYTE_W] <= data_sram_wdata[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Out-of-window reads still complete, returning zero instead of an aliased word.
  assign rd_word = in_range ? mem[idx] : '0;

  data_sram_responder_sram_rd_pipe #(
    .DEPTH (READ_LATENCY),
    .WIDTH (WORD_W)
  ) u_rd_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (kind == ACC_READ),
    .in_data   (rd_word),
    .out_valid (data_sram_rvalid),
    .out_data  (data_sram_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      range_err_q <= 1'b0;
      err_addr_q  <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      if (kind != ACC_IDLE && !in_range && !range_err_q) begin
        range_err_q <= 1'b1;
        err_addr_q  <= data_sram_addr;
      end
      if (kind == ACC_READ && rd_count_q != '1) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (kind == ACC_WRITE && in_range && wr_count_q != '1) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  assign range_err = range_err_q;
  assign err_addr  = err_addr_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (latency 1 and 3) share stimulus
// and are compared each cycle against a queue-based model of the memory contract.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  localparam int          ADDR_W = 6;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'b0000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata1, rdata3, err_addr1, err_addr3, rdc1, rdc3, wrc1, wrc3;
  logic        rv1, rv3, re1, re3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .READ_LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
    .data_sram_rvalid(rv1), .range_err(re1), .err_addr(err_addr1),
    .rd_count(rdc1), .wr_count(wrc1)
  );

  data_sram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .READ_LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
    .data_sram_rvalid(rv3), .range_err(re3), .err_addr(err_addr3),
    .rd_count(rdc3), .wr_count(wrc3)
  );

  // Behavioural model: word array, per-latency response queues stamped with the
  // edge on which the response becomes visible.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] m_mem [DEPTH];
  rsp_t        q1[$];
  rsp_t        q3[$];
  logic [31:0] last1, last3, m_rd, m_wr, m_err_addr;
  logic        m_err;
  int          edge_n = 0;

  logic [3:0] wen_tab [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q3.delete();
    last1 = '0;
    last3 = '0;
    m_rd = '0;
    m_wr = '0;
    m_err = 1'b0;
    m_err_addr = '0;
  endtask

  task automatic model_edge();
    logic [31:0] off;
    logic        inr;
    int          i;
    logic [31:0] d;
    edge_n++;
    if (en) begin
      off = addr - BASE;
      inr = (addr >= BASE) && (off / 4 < DEPTH);
      i   = inr ? int'(off / 4) : 0;
      if (!inr && !m_err) begin
        m_err = 1'b1;
        m_err_addr = addr;
      end
      if (wen != 4'b0000) begin
        if (inr) begin
          for (int k = 0; k < 4; k++) begin
            if (wen[k]) m_mem[i][8*k +: 8] = wdata[8*k +: 8];
          end
          if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
        end
      end else begin
        d = inr ? m_mem[i] : 32'h0;
        q1.push_back('{due: edge_n, data: d});
        q3.push_back('{due: edge_n + 2, data: d});
        if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
      end
    end
  endtask

  task automatic compare_all();
    logic v1, v3;
    v1 = 1'b0;
    v3 = 1'b0;
    if (q1.size() > 0 && q1[0].due == edge_n) begin
      last1 = q1[0].data;
      void'(q1.pop_front());
      v1 = 1'b1;
    end
    if (q3.size() > 0 && q3[0].due == edge_n) begin
      last3 = q3[0].data;
      void'(q3.pop_front());
      v3 = 1'b1;
    end
    check("rvalid_l1", 32'(rv1), 32'(v1));
    check("rdata_l1", rdata1, last1);
    check("rvalid_l3", 32'(rv3), 32'(v3));
    check("rdata_l3", rdata3, last3);
    check("range_err_l1", 32'(re1), 32'(m_err));
    check("range_err_l3", 32'(re3), 32'(m_err));
    check("err_addr_l1", err_addr1, m_err_addr);
    check("err_addr_l3", err_addr3, m_err_addr);
    check("rd_count_l1", rdc1, m_rd);
    check("rd_count_l3", rdc3, m_rd);
    check("wr_count_l1", wrc1, m_wr);
    check("wr_count_l3", wrc3, m_wr);
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e;
    wen = w;
    addr = a;
    wdata = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      req(1'b0, 4'($urandom), $urandom, $urandom);
    end
  endtask

  initial begin
    logic [5:0]  hist;
    logic        seen;
    logic [31:0] a;
    logic [3:0]  w;
    int          r;

    wen_tab = '{WEN_WORD, WEN_B0, WEN_B1, WEN_B2, WEN_B3, WEN_H0, WEN_H1};
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_rdata", rdata1, 32'h0);
    check("reset_rvalid", 32'(rv3), 32'h0);
    check("reset_rd_count", rdc1, 32'h0);
    check("reset_err_addr", err_addr3, 32'h0);
    resetn = 1'b1;

    // Fill every word so later reads are fully defined.
    for (int i = 0; i < DEPTH; i++) begin
      req(1'b1, WEN_WORD, BASE + 32'(4 * i), $urandom);
    end

    // Full-word write then read-back on the next cycle.
    req(1'b1, WEN_WORD, BASE + 32'h10, 32'hDEAD_BEEF);
    req(1'b1, WEN_READ, BASE + 32'h10, 32'h0);
    check("t1_rdata", rdata1, 32'hDEAD_BEEF);
    check("t1_rvalid_on", 32'(rv1), 32'h1);
    idle(1);
    check("t1_rvalid_off", 32'(rv1), 32'h0);
    check("t1_rdata_hold", rdata1, 32'hDEAD_BEEF);
    idle(2);

    // Partial-lane merges.
    req(1'b1, WEN_B1, BASE + 32'h10, 32'h0000_AA00);
    req(1'b1, WEN_H1, BASE + 32'h10, 32'h1234_0000);
    req(1'b1, WEN_READ, BASE + 32'h10, 32'h0);
    check("t2_merge", rdata1, 32'h1234_AAEF);
    idle(3);
    check("t2_merge_l3", rdata3, 32'h1234_AAEF);

    // Back-to-back reads through the 3-deep pipeline.
    for (int s = 0; s < 6; s++) begin
      if (s < 3) req(1'b1, WEN_READ, BASE + 32'(4 * s), 32'h0);
      else       idle(1);
      hist[s] = rv3;
    end
    check("t3_pulse_pattern", 32'(hist), 32'h0000_001C);

    // Out-of-range write/read and sticky capture.
    req(1'b1, WEN_WORD, BASE + 32'(4 * DEPTH), 32'h0000_0055);
    check("t4_range_err", 32'(re1), 32'h1);
    check("t4_err_addr", err_addr1, 32'h0000_0200);
    req(1'b1, WEN_READ, BASE + 32'(4 * DEPTH), 32'h0);
    check("t4_oor_rdata", rdata1, 32'h0);
    req(1'b1, WEN_READ, BASE, 32'h0);
    req(1'b1, WEN_READ, BASE - 32'h4, 32'h0);
    check("t4_err_addr_kept", err_addr1, 32'h0000_0200);
    idle(3);

    // Reset while a latency-3 response is still in flight.
    req(1'b1, WEN_READ, BASE + 32'h20, 32'h0);
    en = 1'b0;
    resetn = 1'b0;
    model_reset();
    #1;
    check("t5_rvalid_l3", 32'(rv3), 32'h0);
    check("t5_rd_count", rdc3, 32'h0);
    check("t5_range_err", 32'(re1), 32'h0);
    step();
    step();
    resetn = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 5; j++) begin
      idle(1);
      seen = seen | rv1 | rv3;
    end
    check("t5_no_stale_rvalid", 32'(seen), 32'h0);

    // Counter saturation, preloaded just below the limit.
    force dut1.rd_count_q = 32'hFFFF_FFFD;
    force dut3.rd_count_q = 32'hFFFF_FFFD;
    force dut1.wr_count_q = 32'hFFFF_FFFE;
    force dut3.wr_count_q = 32'hFFFF_FFFE;
    #1;
    release dut1.rd_count_q;
    release dut3.rd_count_q;
    release dut1.wr_count_q;
    release dut3.wr_count_q;
    m_rd = 32'hFFFF_FFFD;
    m_wr = 32'hFFFF_FFFE;
    for (int j = 0; j < 4; j++) req(1'b1, WEN_READ, BASE + 32'(4 * j), 32'h0);
    for (int j = 0; j < 3; j++) req(1'b1, WEN_H0, BASE + 32'(4 * j), $urandom);
    check("t6_rd_saturated", rdc1, 32'hFFFF_FFFF);
    check("t6_wr_saturated", wrc3, 32'hFFFF_FFFF);
    idle(3);

    // Clean slate, then randomized traffic.
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 32'(4 * $urandom_range(1, 8));
        else                           a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) w = 4'($urandom_range(1, 15));
      else                           w = wen_tab[$urandom_range(0, 6)];
      if (r < 2)      idle(1);
      else if (r < 6) req(1'b1, WEN_READ, a, $urandom);
      else            req(1'b1, w, a, $urandom);
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
